// File: rtl/boundary_scroll_ctrl.sv
// boundary_scroll_ctrl: loads new river-boundary rows into a 480-row ring memory during vblank and moves read_base onto each new top row.
//   clk, reset_n           : clock and asynchronous active-low reset
//   frame_start/speed/pause: per-frame request, speed and pause are sampled only on frame_start
//   row_valid/row_data/row_ready : row handshake with the terrain generator
//   mem_wren/mem_wraddr/mem_wdata: boundary memory write port
//   read_base              : ring offset of display row 0
//   busy/rows_scrolled/underrun  : status
module boundary_scroll_ctrl #(
  parameter int ROWS = 480,
  parameter int DW   = 40,
  parameter int AW   = 9,
  parameter int SW   = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          frame_start,
  input  logic [SW-1:0] speed,
  input  logic          pause,
  input  logic          row_valid,
  input  logic [DW-1:0] row_data,
  output logic          row_ready,
  output logic          mem_wren,
  output logic [AW-1:0] mem_wraddr,
  output logic [DW-1:0] mem_wdata,
  output logic [AW-1:0] read_base,
  output logic          busy,
  output logic [15:0]   rows_scrolled,
  output logic          underrun
);
  typedef enum logic [1:0] {IDLE, FETCH, WRITE} state_t;
  state_t state, next;
  logic [SW-1:0] remaining, rem_dec;
  logic [DW-1:0] row_q;
  logic [AW-1:0] top_slot;
  logic start, take, rem_more;
  assign top_slot = (read_base == '0) ? AW'(ROWS - 1) : read_base - 1'b1;
  assign start    = frame_start && !pause && speed != '0;
  // a new frame preempts the handshake, so the row offered in that cycle is not taken
  assign take     = state == FETCH && row_valid && !frame_start;
  assign rem_dec  = remaining - 1'b1;
  assign rem_more = rem_dec != '0;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= next;
  always_comb begin
    next = frame_start       ? (start ? FETCH : IDLE) :
           state == FETCH    ? (row_valid ? WRITE : FETCH) :
           state == WRITE    ? (rem_more ? FETCH : IDLE) : IDLE;
  end
  always_comb begin
    row_ready  = state == FETCH;
    mem_wren   = state == WRITE;
    mem_wraddr = mem_wren ? top_slot : '0;
    mem_wdata  = mem_wren ? row_q : '0;
    busy       = state != IDLE;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      remaining     <= '0;
      row_q         <= '0;
      read_base     <= '0;
      rows_scrolled <= '0;
      underrun      <= 1'b0;
    end else begin
      // a frame_start discards whatever is left of the previous batch
      remaining     <= frame_start ? (start ? speed : '0) : (state == WRITE ? rem_dec : remaining);
      row_q         <= take ? row_data : row_q;
      read_base     <= state == WRITE ? top_slot : read_base;
      rows_scrolled <= rows_scrolled + 16'(state == WRITE);
      underrun      <= frame_start && (state == FETCH || (state == WRITE && rem_more));
    end
endmodule

// File: doc/boundary_scroll_ctrl.md
Name: boundary_scroll_ctrl

Overview:
Sequences the scrolling of the circular river-boundary memory: 480 rows of 40-bit boundary descriptors, read by the display as (y + read_base) mod 480.
- Once per frame, during vertical blank, it pulls SPEED new rows from the terrain generator over a valid/ready handshake.
- Each row is written into the slot just above the current top row, and read_base is then moved onto that slot, scrolling the river down one row.
- It owns the memory write port and read_base; the display owns the read port.

Parameters:
ROWS, 480, number of rows in the boundary memory (ring length)
DW, 40, boundary row width in bits
AW, 9, address width; 2^AW >= ROWS
SW, 3, width of speed input (rows per frame)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
frame_start  input  1  single-cycle pulse at start of vertical blank
speed  input  SW  rows to scroll this frame; sampled only on frame_start
pause  input  1  freeze scrolling; sampled only on frame_start
row_valid  input  1  generator has a row on row_data
row_data  input  DW  next boundary row (new top row)
row_ready  output  1  controller accepts a row this cycle
mem_wren  output  1  boundary memory write enable
mem_wraddr  output  AW  boundary memory write address
mem_wdata  output  DW  boundary memory write data
read_base  output  AW  ring offset of display row 0
busy  output  1  high whenever state != IDLE
rows_scrolled  output  16  wrapping count of completed row writes
underrun  output  1  single-cycle pulse when a frame ends with rows undelivered

Behaviour:
- Reset (async assert, sync release) sets outputs and state as follows:
  - state IDLE; read_base=0; rows_scrolled=0; remaining=0.
  - row_ready=0, mem_wren=0, mem_wraddr=0, mem_wdata=0, busy=0, underrun=0.
  - Reset mid-batch abandons the batch with no write and no underrun pulse.
- Top-slot address: top_slot = (read_base==0) ? ROWS-1 : read_base-1. There is no % operator in RTL.
- State machine, IDLE / FETCH / WRITE:
  - IDLE, frame_start with pause=0 and speed!=0: remaining <= speed; next FETCH.
  - IDLE, frame_start with pause=1 or speed=0: no action.
  - FETCH: row_ready=1 (combinational from state). When row_valid && row_ready: latch row_data into the write register; next WRITE.
  - WRITE, one cycle, all outputs registered:
    - mem_wren=1, mem_wraddr=top_slot, mem_wdata=latched row.
    - At the closing edge: read_base <= top_slot; rows_scrolled++ (wraps at 2^16); remaining--.
    - Next state FETCH if remaining after decrement != 0, else IDLE.
- Latency:
  - frame_start at cycle 0 gives row_ready=1 at cycle 1.
  - Handshake at cycle k gives mem_wren=1 at cycle k+1; new read_base is visible at cycle k+2.
  - Minimum 2 cycles per row; back-to-back rows accepted every 2 cycles.
- Data integrity:
  - row_data is captured only on handshake; a change while in WRITE is ignored.
  - mem_wren is never high outside WRITE.
  - read_base changes only at the end of WRITE.
- Ring wrap: read_base 0 → write at 479, read_base becomes 479; 479 → 478. Addresses stay in 0..ROWS-1.
- frame_start while in FETCH (batch late):
  - underrun pulses the next cycle; the pending row is not taken.
  - remaining is discarded; the new frame is evaluated as in IDLE in the same cycle.
- frame_start while in WRITE:
  - The current write and read_base update complete.
  - underrun pulses only if the post-decrement remaining != 0.
  - The new frame is then evaluated as in IDLE in the same cycle. Next state is FETCH (new remaining) or IDLE.
- row_valid while IDLE or WRITE is ignored; row_ready=0 there.
- speed/pause changes outside frame_start have no effect on an active batch.

Test Plan:
- Reset then frame_start, speed=1, row_valid held with row_data=40'hA5A5A5A5A5 → row_ready cycle 1, mem_wren cycle 2 with mem_wraddr=479 and data A5A5A5A5A5; read_base=479 and rows_scrolled=1 from cycle 3; busy low after.
- frame_start, speed=3, row_valid always high, rows D0,D1,D2 → writes to 478,477,476 at 2-cycle spacing; read_base ends 476; rows_scrolled +3; no underrun.
- Ring wrap: advance to read_base=1, then speed=2 → writes at addresses 0 then 479; final read_base=479.
- speed=4, generator supplies 1 row then stalls, next frame_start with speed=2 → one write only; underrun pulses once; new batch of 2 starts immediately (row_ready stays high).
- frame_start with pause=1 speed=7, and with pause=0 speed=0 → no row_ready, no writes, read_base unchanged, busy stays 0.
- Assert reset_n low while in FETCH with remaining=5 → all outputs reset immediately (asynchronous); no mem_wren, no underrun after release; read_base=0.
